// File: rtl/div_pkg.sv
// Shared definitions for the divider scheduler: FSM encoding and
// the fixed result constants.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;
  localparam int          DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins one past the
// previous winner and wraps, so every requester is eventually served.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant
);

  always_comb begin
    logic w_found;
    int   w_idx;
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 1; off <= N; off++) begin
      w_idx = (int'(last_grant) + off) % N;
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_16bit_sched.sv
// Shares one external 16-bit divider between NUM_REQ requesters with
// round-robin arbitration, divide-by-zero bypass and a WAIT timeout.
module div_16bit_sched
  import div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_result,
  output logic [15:0]           rsp_remainder,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  div_start,
  output logic [15:0]           div_a,
  output logic [15:0]           div_b,
  input  logic                  div_done,
  input  logic [15:0]           div_result,
  input  logic [15:0]           div_remainder
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t               r_state;
  logic [IW-1:0]        r_lastGrant;
  logic [IW-1:0]        r_grantIdx;
  logic [15:0]          r_opA;
  logic [15:0]          r_opB;
  logic [CW-1:0]        r_waitCnt;
  logic                 r_divStart;
  logic [NUM_REQ-1:0]   r_rspValid;
  logic [15:0]          r_rspResult;
  logic [15:0]          r_rspRem;
  logic                 r_rspErr;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IW-1:0]        w_grantIdx;
  logic [15:0]          w_selA;
  logic [15:0]          w_selB;
  logic                 w_accept;
  logic                 w_divActive;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (r_lastGrant),
    .grant      (w_grant)
  );

  always_comb begin
    w_grantIdx = '0;
    w_selA     = '0;
    w_selB     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_grantIdx = IW'(i);
        w_selA     = req_a[16*i +: 16];
        w_selB     = req_b[16*i +: 16];
      end
    end
  end

  // Ready is offered only from IDLE, so at most one request is in flight.
  assign w_accept    = (r_state == IDLE) && (|w_grant);
  assign req_ready   = (r_state == IDLE) ? w_grant : '0;
  assign w_divActive = (r_state == ISSUE) || (r_state == WAIT);

  assign div_a         = w_divActive ? r_opA : 16'd0;
  assign div_b         = w_divActive ? r_opB : 16'd0;
  assign div_start     = r_divStart;
  assign busy          = (r_state != IDLE);
  assign rsp_valid     = r_rspValid;
  assign rsp_result    = r_rspResult;
  assign rsp_remainder = r_rspRem;
  assign rsp_err       = r_rspErr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= IW'(NUM_REQ - 1);
      r_grantIdx  <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_waitCnt   <= '0;
      r_divStart  <= 1'b0;
      r_rspValid  <= '0;
      r_rspResult <= '0;
      r_rspRem    <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      r_divStart <= 1'b0;
      r_rspValid <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opA      <= w_selA;
            r_opB      <= w_selB;
            r_grantIdx <= w_grantIdx;
            // A zero divisor never reaches the divider.
            if (w_selB == 16'd0) begin
              r_rspResult <= DIV_ZERO_RESULT;
              r_rspRem    <= w_selA;
              r_rspErr    <= 1'b1;
              r_rspValid  <= w_grant;
              r_state     <= RESP;
            end else begin
              r_divStart <= 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_waitCnt <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          // Done is tested first so it wins over a coincident timeout.
          if (div_done) begin
            r_rspResult <= div_result;
            r_rspRem    <= div_remainder;
            r_rspErr    <= 1'b0;
            r_rspValid  <= NUM_REQ'(1) << r_grantIdx;
            r_state     <= RESP;
          end else if (r_waitCnt == CW'(TIMEOUT - 1)) begin
            r_rspResult <= 16'd0;
            r_rspRem    <= 16'd0;
            r_rspErr    <= 1'b1;
            r_rspValid  <= NUM_REQ'(1) << r_grantIdx;
            r_state     <= RESP;
          end else begin
            r_waitCnt <= r_waitCnt + CW'(1);
          end
        end
        RESP: begin
          r_lastGrant <= r_grantIdx;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16bit_sched.sv
// Directed bench for div_16bit_sched; the bench itself plays the role
// of the shared divider by driving div_done/div_result by hand.
module tb_div_16bit_sched;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_result;
  logic [15:0]       rsp_remainder;
  logic              rsp_err;
  logic              busy;
  logic              div_start;
  logic [15:0]       div_a;
  logic [15:0]       div_b;
  logic              div_done;
  logic [15:0]       div_result;
  logic [15:0]       div_remainder;

  int testsRun    = 0;
  int testsFailed = 0;

  div_16bit_sched #(.NUM_REQ(NREQ), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .div_start     (div_start),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_done      (div_done),
    .div_result    (div_result),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  initial begin
    logic [3:0] expOH;
    int n;

    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    div_done = 1'b0; div_result = '0; div_remainder = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rspv", 32'(rsp_valid), 32'd0);
    checkOutput("rst_start", 32'(div_start), 32'd0);
    checkOutput("rst_diva", 32'(div_a), 32'd0);
    checkOutput("rst_result", 32'(rsp_result), 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);

    // Single request 100 / 7 from requester 0
    applyStimulus(0, 16'd100, 16'd7);
    req_valid = 4'b0001;
    #1;
    checkOutput("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    checkOutput("t1_start", 32'(div_start), 32'd1);
    checkOutput("t1_diva", 32'(div_a), 32'd100);
    checkOutput("t1_divb", 32'(div_b), 32'd7);
    checkOutput("t1_ready_busy", 32'(req_ready), 32'd0);
    tick();
    checkOutput("t1_start_low", 32'(div_start), 32'd0);
    checkOutput("t1_diva_wait", 32'(div_a), 32'd100);
    div_done = 1'b1; div_result = 16'd14; div_remainder = 16'd2;
    tick();
    div_done = 1'b0;
    checkOutput("t1_rspv", 32'(rsp_valid), 32'h1);
    checkOutput("t1_result", 32'(rsp_result), 32'd14);
    checkOutput("t1_rem", 32'(rsp_remainder), 32'd2);
    checkOutput("t1_err", 32'(rsp_err), 32'd0);
    checkOutput("t1_diva_resp", 32'(div_a), 32'd0);
    tick();
    checkOutput("t1_rspv_off", 32'(rsp_valid), 32'd0);
    checkOutput("t1_hold", 32'(rsp_result), 32'd14);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // All requesters valid after reset: grant order 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 16'(100 + i), 16'(i + 1));
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      expOH = 4'b0001 << (k % 4);
      checkOutput($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(expOH));
      tick();
      checkOutput($sformatf("rr_issue_ready%0d", k), 32'(req_ready), 32'd0);
      tick();
      checkOutput($sformatf("rr_wait_ready%0d", k), 32'(req_ready), 32'd0);
      div_done = 1'b1; div_result = 16'(k); div_remainder = 16'(k + 10);
      tick();
      div_done = 1'b0;
      checkOutput($sformatf("rr_rspv%0d", k), 32'(rsp_valid), 32'(expOH));
      checkOutput($sformatf("rr_result%0d", k), 32'(rsp_result), 32'(k));
      tick();
    end
    req_valid = '0;

    // Divide by zero from requester 2
    applyStimulus(2, 16'd1234, 16'd0);
    req_valid = 4'b0100;
    #1;
    checkOutput("dz_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    checkOutput("dz_rspv", 32'(rsp_valid), 32'h4);
    checkOutput("dz_start", 32'(div_start), 32'd0);
    checkOutput("dz_result", 32'(rsp_result), 32'hFFFF);
    checkOutput("dz_rem", 32'(rsp_remainder), 32'd1234);
    checkOutput("dz_err", 32'(rsp_err), 32'd1);
    tick();
    checkOutput("dz_rspv_off", 32'(rsp_valid), 32'd0);
    checkOutput("dz_err_hold", 32'(rsp_err), 32'd1);

    // Timeout: requester 3, divider never answers
    applyStimulus(3, 16'd50, 16'd5);
    req_valid = 4'b1000;
    #1;
    checkOutput("to_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("to_cycles", 32'(n), 32'(TO));
    checkOutput("to_rspv", 32'(rsp_valid), 32'h8);
    checkOutput("to_err", 32'(rsp_err), 32'd1);
    checkOutput("to_result", 32'(rsp_result), 32'd0);
    checkOutput("to_rem", 32'(rsp_remainder), 32'd0);
    tick();
    applyStimulus(1, 16'd20, 16'd4);
    req_valid = 4'b0010;
    #1;
    checkOutput("to_next_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    div_done = 1'b1; div_result = 16'd5; div_remainder = 16'd0;
    tick();
    div_done = 1'b0;
    checkOutput("to_next_result", 32'(rsp_result), 32'd5);
    tick();

    // Reset during WAIT aborts the operation
    applyStimulus(2, 16'd77, 16'd7);
    req_valid = 4'hF;
    #1;
    checkOutput("rw_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checkOutput("rw_rspv", 32'(rsp_valid), 32'd0);
    checkOutput("rw_start", 32'(div_start), 32'd0);
    checkOutput("rw_busy", 32'(busy), 32'd0);
    checkOutput("rw_diva", 32'(div_a), 32'd0);
    checkOutput("rw_result", 32'(rsp_result), 32'd0);
    checkOutput("rw_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    req_valid = 4'hF;
    #1;
    checkOutput("rw_first", 32'(req_ready), 32'h1);

    // Done coincides with the last timeout cycle: done wins
    tick();
    req_valid = '0;
    checkOutput("dt_diva", 32'(div_a), 32'd100);
    tick();
    for (int j = 0; j < TO - 1; j++) tick();
    checkOutput("dt_pending", 32'(rsp_valid), 32'd0);
    checkOutput("dt_busy", 32'(busy), 32'd1);
    div_done = 1'b1; div_result = 16'd9; div_remainder = 16'd3;
    tick();
    div_done = 1'b0;
    checkOutput("dt_rspv", 32'(rsp_valid), 32'h1);
    checkOutput("dt_err", 32'(rsp_err), 32'd0);
    checkOutput("dt_result", 32'(rsp_result), 32'd9);
    checkOutput("dt_rem", 32'(rsp_remainder), 32'd3);
    tick();
    checkOutput("dt_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
